// File: rtl/me_pkg.sv
// Shared types and derived-width helpers for the full-search motion-estimation engine.
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    CMP,
    DONE
  } state_t;

  // Smallest n with 2**n >= v.
  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Counter width that is never zero.
  function automatic int cw(input longint unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int sww(input int blk, input int range, input int ppw);
    return (blk + range) / ppw;
  endfunction

  function automatic int sad_w(input int blk, input int pix_w);
    return clog2(longint'(blk) * longint'(blk) * ((longint'(1) << pix_w) - 1) + 1);
  endfunction

  function automatic int mv_w(input int range);
    return clog2(range);
  endfunction

  function automatic int sw_aw(input int blk, input int range, input int ppw);
    return clog2((blk + range) * sww(blk, range, ppw));
  endfunction

  function automatic int tb_aw(input int blk, input int ppw);
    return clog2(blk * blk / ppw);
  endfunction

endpackage

// File: rtl/me_sad_word.sv
// Combinational SAD of one memory word: aligns PPW search pixels out of two
// consecutive sw words and sums their absolute differences with a tb word.
module me_sad_word
  import me_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int PPW   = 4,
  localparam int DW    = PPW * PIX_W,
  localparam int OW    = cw(PPW),
  localparam int SD_W  = PIX_W + clog2(PPW)
) (
  input  logic [DW-1:0]   sw_lo,
  input  logic [DW-1:0]   sw_hi,
  input  logic [OW-1:0]   off,
  input  logic [DW-1:0]   tb_word,
  output logic [SD_W-1:0] sad
);

  logic [DW-1:0] win;

  assign win = DW'({sw_hi, sw_lo} >> (int'(off) * PIX_W));

  // Sum of per-pixel unsigned absolute differences.
  always_comb begin
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    a   = '0;
    b   = '0;
    sad = '0;
    for (int unsigned i = 0; i < PPW; i++) begin
      a   = win[i*PIX_W +: PIX_W];
      b   = tb_word[i*PIX_W +: PIX_W];
      sad = sad + SD_W'((a > b) ? (a - b) : (b - a));
    end
  end

endmodule

// File: rtl/me_full_search_param.sv
// Parametrised full-search block-matching ME engine with req/ack handshake
// and optional early termination of losing candidates.
module me_full_search_param
  import me_pkg::*;
#(
  parameter  int PIX_W      = 8,
  parameter  int PPW        = 4,
  parameter  int BLK        = 16,
  parameter  int RANGE      = 16,
  parameter  int EARLY_TERM = 0,
  localparam int SWW        = sww(BLK, RANGE, PPW),
  localparam int SAD_W      = sad_w(BLK, PIX_W),
  localparam int MV_W       = mv_w(RANGE),
  localparam int SW_AW      = sw_aw(BLK, RANGE, PPW),
  localparam int TB_AW      = tb_aw(BLK, PPW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ack,
  output logic                   busy,
  output logic [SAD_W-1:0]       min_sad,
  output logic [2*MV_W-1:0]      min_mvec,
  output logic [SW_AW-1:0]       addr_sw,
  input  logic [PPW*PIX_W-1:0]   pel_sw,
  output logic [TB_AW-1:0]       addr_tb,
  input  logic [PPW*PIX_W-1:0]   pel_tb
);

  localparam int DW   = PPW * PIX_W;
  localparam int WPR  = BLK / PPW;
  localparam int R_W  = cw(BLK);
  localparam int K_W  = cw(WPR + 1);
  localparam int OW   = cw(PPW);
  localparam int SD_W = PIX_W + clog2(PPW);

  state_t             state_q, state_d;
  logic [MV_W-1:0]    h_q, w_q;
  logic [R_W-1:0]     r_q;
  logic [K_W-1:0]     k_q;
  logic [SAD_W-1:0]   acc_q, best_q;
  logic [2*MV_W-1:0]  bmv_q;
  logic               v_q, row_end_q, ack_q;
  logic [DW-1:0]      prev_q;
  logic [OW-1:0]      off;
  logic [SD_W-1:0]    sad_word;
  logic [SAD_W-1:0]   acc_sum;
  logic               last_k, last_row, last_cand, et_hit;

  assign off       = OW'(int'(w_q) % PPW);
  assign last_k    = (k_q == K_W'(WPR));
  assign last_row  = (r_q == R_W'(BLK - 1));
  assign last_cand = (h_q == MV_W'(RANGE - 1)) && (w_q == MV_W'(RANGE - 1));
  assign acc_sum   = acc_q + SAD_W'(sad_word);
  // Row-end abandon: the very first candidate is exempt so best always gets a real SAD.
  assign et_hit    = (EARLY_TERM != 0) && v_q && row_end_q &&
                     !((h_q == '0) && (w_q == '0)) && (acc_sum >= best_q);

  assign addr_sw = (state_q == SCAN) ?
                   SW_AW'((int'(h_q) + int'(r_q)) * SWW + int'(w_q) / PPW + int'(k_q)) : '0;
  assign addr_tb = (state_q == SCAN && k_q != '0) ?
                   TB_AW'(int'(r_q) * WPR + int'(k_q) - 1) : '0;
  assign busy    = (state_q == SCAN) || (state_q == DRAIN) || (state_q == CMP);
  assign ack     = ack_q;

  me_sad_word #(
    .PIX_W (PIX_W),
    .PPW   (PPW)
  ) u_sad (
    .sw_lo   (prev_q),
    .sw_hi   (pel_sw),
    .off     (off),
    .tb_word (pel_tb),
    .sad     (sad_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; req low aborts any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = SCAN;
      SCAN: begin
        if (!req)                     state_d = IDLE;
        else if (et_hit)              state_d = CMP;
        else if (last_k && last_row)  state_d = DRAIN;
      end
      DRAIN:   state_d = req ? CMP : IDLE;
      CMP: begin
        if (!req)           state_d = IDLE;
        else if (last_cand) state_d = DONE;
        else                state_d = SCAN;
      end
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan counters, read pipeline, accumulator, best tracking and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q       <= '0;
      w_q       <= '0;
      r_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      best_q    <= '0;
      bmv_q     <= '0;
      v_q       <= 1'b0;
      row_end_q <= 1'b0;
      prev_q    <= '0;
      ack_q     <= 1'b0;
      min_sad   <= '0;
      min_mvec  <= '0;
    end else begin
      prev_q    <= pel_sw;
      v_q       <= 1'b0;
      row_end_q <= 1'b0;
      ack_q     <= (state_q == DONE) && (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (req) begin
            h_q    <= '0;
            w_q    <= '0;
            r_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            best_q <= '1;
          end
        end
        SCAN: begin
          if (v_q) acc_q <= acc_sum;
          if (et_hit) begin
            r_q <= '0;
            k_q <= '0;
          end else begin
            v_q       <= (k_q != '0);
            row_end_q <= last_k;
            if (last_k) begin
              k_q <= '0;
              r_q <= last_row ? '0 : r_q + R_W'(1);
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        DRAIN: begin
          if (v_q) acc_q <= acc_sum;
          r_q <= '0;
          k_q <= '0;
        end
        CMP: begin
          if (acc_q < best_q) begin
            best_q <= acc_q;
            bmv_q  <= {h_q, w_q};
          end
          acc_q <= '0;
          w_q   <= w_q + MV_W'(1);
          if (w_q == MV_W'(RANGE - 1)) h_q <= h_q + MV_W'(1);
        end
        DONE: begin
          if (!ack_q) begin
            min_sad  <= best_q;
            min_mvec <= bmv_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/me_full_search_param.md
Name: me_full_search_param

Overview:
- Parametrised full-search block-matching motion-estimation engine; next generation of the fixed-size double-pixel ME processor.
- Scans every candidate displacement (h,w) in a RANGE×RANGE search area and accumulates the SAD between a BLK×BLK template block and the displaced search-window block.
- Reads PPW pixels per memory word from external search-window (sw) and template (tb) memories, which have synchronous read and 1-cycle latency.
- Reports minimum SAD and its motion vector through a level req/ack handshake, with optional early termination.

Parameters:
- PIX_W, 8: bits per pixel.
- PPW, 4: pixels per memory word; memory data width is PPW*PIX_W.
- BLK, 16: template block side in pixels; must be a multiple of PPW.
- RANGE, 16: candidate positions per axis; must be a multiple of PPW and a power of 2.
- EARLY_TERM, 0: 1 enables abandoning a candidate once its partial SAD ≥ best SAD.
- Derived widths:
  - SWW = (BLK+RANGE)/PPW, words per sw row.
  - SAD_W = clog2(BLK*BLK*(2^PIX_W-1)+1).
  - MV_W = clog2(RANGE).
  - SW_AW = clog2((BLK+RANGE)*SWW).
  - TB_AW = clog2(BLK*BLK/PPW).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- req, in, 1: level request; start when high in IDLE; must be held until ack is seen.
- ack, out, 1: result valid; held high until req is low.
- busy, out, 1: high in any state except IDLE and DONE.
- min_sad, out, SAD_W: minimum SAD of the last completed search.
- min_mvec, out, 2*MV_W: {h,w} of min_sad.
- addr_sw, out, SW_AW: sw word address = row*SWW + word.
- pel_sw, in, PPW*PIX_W: sw data, 1 cycle after address; pixel 0 in the LSBs.
- addr_tb, out, TB_AW: tb word address = row*(BLK/PPW) + word.
- pel_tb, in, PPW*PIX_W: tb data, 1 cycle after address.

Behaviour:
- Reset: state IDLE; ack=0, busy=0, min_sad=0, min_mvec=0, addr_sw=0, addr_tb=0; all internal counters and accumulators cleared. Reset mid-search aborts with no ack.
- States:
  - IDLE→SCAN when req=1. Loads h=0, w=0, best=all-ones, and clears the accumulator.
  - SCAN, per candidate: for each row r=0..BLK-1, issue k=0..BLK/PPW (BLK/PPW+1 cycles).
    - addr_sw = (h+r)*SWW + w/PPW + k.
    - addr_tb = r*(BLK/PPW) + (k-1), for k≥1; don't-care at k=0.
  - Unaligned extraction: keep the previous sw word. When word k arrives, the concatenation {word k, word k-1} shifted right by (w mod PPW)*PIX_W gives PPW sw pixels. These are matched against tb word k-1: sum of PPW absolute differences added to the accumulator.
  - DRAIN: 1 cycle for the last read's latency.
  - CMP: 1 cycle. If acc < best (strictly), set best=acc and bmv={h,w}. Then advance w, wrapping to 0 and incrementing h.
    - After h=w=RANGE-1 → DONE.
    - Otherwise clear acc → SCAN.
  - DONE: ack=1. min_sad and min_mvec are registered from best/bmv on DONE entry, and only there. DONE→IDLE when req=0; ack falls on the same edge.
- Latency with EARLY_TERM=0:
  - Per candidate: BLK*(BLK/PPW+1)+2 cycles.
  - ack rises exactly RANGE²*(BLK*(BLK/PPW+1)+2)+1 cycles after the edge that samples req=1 in IDLE.
- Early termination (EARLY_TERM=1): at the end of each row, after that row's last accumulate, if acc ≥ best, skip to CMP. The in-flight read is discarded and the candidate cannot win.
  - Result is bit-identical to EARLY_TERM=0.
  - The first candidate always completes.
- Tie-break: strict < in raster order, h-major, so the earliest candidate wins ties.
- Arithmetic:
  - Absolute differences are unsigned PIX_W bits.
  - The accumulator is SAD_W bits and cannot overflow by construction; no saturation logic.
- req falling in SCAN/DRAIN/CMP: abort to IDLE next edge. No ack; min_sad and min_mvec keep their old values.
- req high in DONE: stay in DONE. A new search needs req low for at least 1 cycle.

Decomposition:
- Package me_pkg: state enum (IDLE, SCAN, DRAIN, CMP, DONE), and the derived-width functions (clog2, SWW, SAD_W, MV_W, SW_AW, TB_AW).
- Sub-module me_sad_word: combinational. Inputs are the two sw words, the shift offset and the tb word; output is the PPW-pixel SAD (width PIX_W+clog2(PPW)).
- All counters, FSM and address generation stay in the top level.

Test Plan:
- Small config BLK=4, PPW=4, RANGE=4, EARLY_TERM=0; sw random, with the tb pattern embedded at (h=2,w=3) → min_sad=0, min_mvec={2,3}, ack exactly 161 cycles after the req sample.
- sw and tb all 0x10 → every SAD 0 → min_mvec={0,0} (tie-break), min_sad=0.
- Default config; tb all 0xFF, sw all 0x00 → min_sad=65280, min_mvec={0,0}. Checks full accumulator width.
- Same random data run with EARLY_TERM=0 and EARLY_TERM=1 → identical min_sad/min_mvec; EARLY_TERM=1 ack cycle count strictly lower.
- req dropped 50 cycles into SCAN → busy=0 and IDLE on the next edge, no ack, outputs equal the previous result. Re-request → correct result.
- rst pulsed mid-SCAN → all outputs 0 on the next edge, ack never asserted. Hold req high through DONE for 10 cycles → ack stays 1 and falls on the edge after req=0.
